memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Data-memory stage of the Y86 SEQ processor, directly downstream of execute.
- Consumes icode, ValE, ValA and ValP for one instruction per start pulse and performs the Y86 memory access.
- Returns ValM to decode_wb and raises dmem_error for out-of-range addresses.
- Models a multi-cycle data memory with a start/done handshake, so the processor stalls while busy is high.

Parameters:
- DEPTH, 256: number of 64-bit words. Addresses are word indices 0..DEPTH-1.
- LATENCY, 2: cycles from start to done for an in-range memory access. Legal range is 1..15.

Ports:
- clk, input, 1: clock, rising-edge active.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request from the execute stage.
- icode, input, 4: instruction code.
- ValE, input, 64: ALU result, used as the address for rmmovq, mrmovq, pushq and call.
- ValA, input, 64: store data for rmmovq and pushq; address for popq and ret.
- ValP, input, 64: return address stored by call.
- ValM, output, 64: read data. Registered and held.
- done, output, 1: one-cycle completion pulse.
- busy, output, 1: high while a request is in flight.
- dmem_error, output, 1: address error for the completed request. Registered and held.

Behaviour:
- Reset is asynchronous. It forces ValM=0, done=0, busy=0, dmem_error=0 and state IDLE. The latency counter returns to 0.
- Access decode, latched when start is accepted:
  - icode 4 (rmmovq): write mem[ValE]=ValA.
  - icode A (pushq): write mem[ValE]=ValA.
  - icode 8 (call): write mem[ValE]=ValP.
  - icode 5 (mrmovq): read ValM=mem[ValE].
  - icode B (popq) and icode 9 (ret): read ValM=mem[ValA].
  - Any other icode: no access.
- States are IDLE, WAIT and RESP.
  - IDLE: busy=0. When start=1, latch icode, the address, the write data and the operation kind.
    - No-access op, or address >= DEPTH: go to RESP.
    - Otherwise: go to WAIT with counter=LATENCY-1.
    - If LATENCY=1, go straight to RESP.
  - WAIT: busy=1. The counter decrements each cycle. At counter=1, go to RESP.
  - RESP: busy=1 and done=1 for exactly one cycle, then return to IDLE.
- Timing:
  - An in-range access has done high in cycle N+LATENCY, where the start edge is cycle N.
  - A no-access op or an error has done high in cycle N+1.
- Commit: the write and the ValM/dmem_error updates happen on the same clock edge that raises done.
  - A read captures mem[addr] on that edge.
  - A no-access op sets ValM=0 and dmem_error=0.
  - An error performs no write and sets ValM=0 and dmem_error=1.
- Outside the commit edge, ValM and dmem_error hold their previous values.
- start is ignored while busy=1. It is not queued.
- A new start is accepted in the cycle after RESP. Back-to-back throughput is one request per LATENCY+1 cycles.
- Address compare uses the full 64-bit unsigned value. For example, 64'hFFFF_FFFF_FFFF_FFF8 is an error and does not wrap.
- Reset asserted mid-operation aborts the request with no write. Memory contents are retained unless the optional feature below is enabled.
- Latched inputs are used for the entire operation. Input changes after the start cycle have no effect.

Optional Feature:
- Macro DMEM_CLEAR_ON_RESET_EN.
- Defined: reset also clears every memory word to 0.
- Undefined: reset leaves memory contents untouched. Only the FSM and the outputs reset.

Test Plan:
1. rmmovq write then read: start with icode=4, ValE=2, ValA=64'd77. Then start with icode=5, ValE=2. Expect done 2 cycles after each start, then ValM=77 and dmem_error=0.
2. call/ret pair: icode=8, ValE=100, ValP=54, then icode=9, ValA=100. Expect ValM=54. busy is high 2 cycles per request and start is ignored during busy.
3. Out-of-range: icode=A, ValE=300, ValA=5. Expect done 1 cycle after start, dmem_error=1, ValM=0. A subsequent read of word 300 mod 256 = 44 shows it unchanged.
4. No-access op: icode=6 (OPq). Expect done after 1 cycle, ValM=0, dmem_error=0, and no memory change.
5. Reset mid-access: start icode=4, ValE=3, ValA=9, then assert reset in the WAIT cycle. Expect all outputs 0 and no done. A later read of word 3 returns its prior value.
6. With DMEM_CLEAR_ON_RESET_EN defined: write word 2=77, pulse reset, read word 2. Expect ValM=0. Without the macro, expect 77.

Source files
------------

// File: rtl/memory_stage.sv
// Y86 SEQ data-memory stage with a multi-cycle start/done handshake and address range checking.
// Optional macro DMEM_CLEAR_ON_RESET_EN: reset also zeroes every memory word.
module memory_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] ValE,
  input  logic [63:0] ValA,
  input  logic [63:0] ValP,
  output logic [63:0] ValM,
  output logic        done,
  output logic        busy,
  output logic        dmem_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_WR   = 2'd2;

  logic [63:0]   mem [DEPTH];

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [1:0]    op_q;
  logic [AW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic          err_q;

  logic [1:0]    dec_op;
  logic [63:0]   dec_addr;
  logic [63:0]   dec_wdata;
  logic          dec_err;
  logic          dec_short;
  logic          accept;
  logic          commit;
  logic [1:0]    c_op;
  logic [AW-1:0] c_idx;
  logic [63:0]   c_wdata;
  logic          c_err;
  logic          mem_we;
  logic [63:0]   rdata;

  always_comb begin
    dec_op    = OP_NONE;
    dec_addr  = ValE;
    dec_wdata = ValA;
    case (icode)
      4'h4, 4'hA: dec_op = OP_WR;
      4'h8: begin
        dec_op    = OP_WR;
        dec_wdata = ValP;
      end
      4'h5: dec_op = OP_RD;
      4'h9, 4'hB: begin
        dec_op   = OP_RD;
        dec_addr = ValA;
      end
      default: dec_op = OP_NONE;
    endcase
  end

  // Full 64-bit compare so huge addresses never alias into the array.
  assign dec_err   = (dec_op != OP_NONE) && (dec_addr >= 64'(DEPTH));
  assign dec_short = (dec_op == OP_NONE) || dec_err || (LATENCY == 1);
  assign accept    = (state == S_IDLE) && start;
  assign commit    = (accept && dec_short) || ((state == S_WAIT) && (cnt == 4'd1));

  // Short requests commit on their start edge, before anything is latched.
  assign c_op    = (state == S_IDLE) ? dec_op             : op_q;
  assign c_idx   = (state == S_IDLE) ? dec_addr[AW-1:0]   : idx_q;
  assign c_wdata = (state == S_IDLE) ? dec_wdata          : wdata_q;
  assign c_err   = (state == S_IDLE) ? dec_err            : err_q;

  assign mem_we = commit && (c_op == OP_WR) && !c_err;
  assign rdata  = mem[c_idx];

  assign busy = (state != S_IDLE);
  assign done = (state == S_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      op_q       <= OP_NONE;
      idx_q      <= '0;
      wdata_q    <= 64'd0;
      err_q      <= 1'b0;
      ValM       <= 64'd0;
      dmem_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q    <= dec_op;
            idx_q   <= dec_addr[AW-1:0];
            wdata_q <= dec_wdata;
            err_q   <= dec_err;
            if (dec_short) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        ValM       <= ((c_op == OP_RD) && !c_err) ? rdata : 64'd0;
        dmem_error <= c_err;
      end
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
    end else if (mem_we) begin
      mem[c_idx] <= c_wdata;
    end
  end
`else
  // Reset drops the FSM back to IDLE, so an in-flight write simply never commits.
  always_ff @(posedge clk) begin
    if (mem_we) mem[c_idx] <= c_wdata;
  end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a word-array reference model.
module tb_memory_stage;
  localparam int DEP = 256;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [63:0] ValE = 64'd0, ValA = 64'd0, ValP = 64'd0;
  logic [63:0] ValM;
  logic        done, busy, dmem_error;

  logic [63:0] mem_m [DEP];
  int n_cmp = 0;
  int n_bad = 0;

  memory_stage #(.DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .ValE(ValE), .ValA(ValA), .ValP(ValP),
    .ValM(ValM), .done(done), .busy(busy), .dmem_error(dmem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One request: predict from the instruction semantics, drive, then wait for done.
  task automatic do_req(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input bit junk, input string nm);
    int kind, lat, c, bc;
    bit seen, xe;
    logic [63:0] ad, wd, xm;
    kind = 0; ad = e; wd = a;
    case (ic)
      4'h4, 4'hA: kind = 2;
      4'h8: begin kind = 2; wd = p; end
      4'h5: kind = 1;
      4'h9, 4'hB: begin kind = 1; ad = a; end
      default: kind = 0;
    endcase
    xe  = (kind != 0) && (ad >= 64'(DEP));
    lat = (kind == 0 || xe) ? 1 : LAT;
    xm  = (kind == 1 && !xe) ? mem_m[ad[7:0]] : 64'd0;
    if (kind == 2 && !xe) mem_m[ad[7:0]] = wd;

    @(negedge clk);
    start = 1'b1; icode = ic; ValE = e; ValA = a; ValP = p;
    @(posedge clk);
    c = 0; bc = 0; seen = 1'b0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      start = 1'b0; icode = 4'($urandom); ValE = rnd64(); ValA = rnd64(); ValP = rnd64();
      if (busy) bc++;
      if (done) seen = 1'b1;
      else if (junk) begin
        start = 1'b1; icode = 4'h4; ValE = 64'($urandom_range(0, DEP - 1));
      end
    end
    start = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s timeout: no done within %0d cycles", nm, c);
    end else begin
      if (c !== lat) begin
        n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, c, lat);
      end
      n_cmp++;
      if (ValM !== xm) begin
        n_bad++; $display("FAIL %s ValM: got %h want %h", nm, ValM, xm);
      end
      n_cmp++;
      if (dmem_error !== xe) begin
        n_bad++; $display("FAIL %s dmem_error: got %b want %b", nm, dmem_error, xe);
      end
      n_cmp++;
      if (bc !== lat) begin
        n_bad++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, bc, lat);
      end
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    n_cmp++;
    if (ValM !== 64'd0 || done !== 1'b0 || busy !== 1'b0 || dmem_error !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: ValM=%h done=%b busy=%b err=%b want all 0", nm, ValM, done, busy, dmem_error);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < DEP; i++) mem_m[i] = 64'd0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_state");
    @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] ops [3];
    ops[0] = 4'h4; ops[1] = 4'hA; ops[2] = 4'h8;
    for (int i = 0; i < DEP; i++)
      do_req(ops[$urandom_range(0, 2)], 64'(i), rnd64(), rnd64(), 1'b0, "fill");
  endtask

  task automatic test_rw_basic();
    do_req(4'h4, 64'd2, 64'd77, 64'd0, 1'b0, "rmmovq_w2");
    do_req(4'h5, 64'd2, 64'd0, 64'd0, 1'b0, "mrmovq_r2");
  endtask

  task automatic test_call_ret();
    do_req(4'h8, 64'd100, rnd64(), 64'd54, 1'b1, "call_100");
    do_req(4'h9, rnd64(), 64'd100, rnd64(), 1'b1, "ret_100");
  endtask

  task automatic test_out_of_range();
    do_req(4'hA, 64'd300, 64'd5, 64'd0, 1'b0, "push_300");
    do_req(4'h5, 64'd44, 64'd0, 64'd0, 1'b0, "read_44");
    do_req(4'h4, 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 64'd0, 1'b0, "rm_huge");
    do_req(4'hB, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, "pop_huge");
    do_req(4'h4, 64'd255, 64'd123, 64'd0, 1'b0, "rm_255");
    do_req(4'h5, 64'd256, 64'd0, 64'd0, 1'b0, "mr_256");
    do_req(4'h5, 64'd255, 64'd0, 64'd0, 1'b0, "mr_255");
  endtask

  task automatic test_no_access();
    do_req(4'h6, 64'd7, 64'd9, 64'd11, 1'b0, "opq");
    do_req(4'h0, 64'd500, 64'd9, 64'd11, 1'b0, "halt_far");
    do_req(4'h5, 64'd7, 64'd0, 64'd0, 1'b0, "read_7");
  endtask

  task automatic test_reset_mid();
    do_req(4'h5, 64'd2, 64'd0, 64'd0, 1'b0, "pre_reset_read");
    @(negedge clk);
    start = 1'b1; icode = 4'h4; ValE = 64'd3; ValA = 64'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < DEP; i++) mem_m[i] = 64'd0;
`endif
    #1;
    check_idle_outputs("mid_reset_async");
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("mid_reset_no_done");
    reset = 1'b0;
    do_req(4'h5, 64'd3, 64'd0, 64'd0, 1'b0, "read_3_after_abort");
  endtask

  task automatic test_reset_clear();
    do_req(4'h4, 64'd2, 64'd77, 64'd0, 1'b0, "w2_before_reset");
    pulse_reset();
    check_idle_outputs("after_pulse_reset");
    do_req(4'h5, 64'd2, 64'd0, 64'd0, 1'b0, "r2_after_reset");
  endtask

  task automatic test_back_to_back();
    int nd, want, bw;
    do_req(4'h4, 64'd9, 64'hABCD, 64'd0, 1'b0, "b2b_seed");
    want = (11 - LAT) / (LAT + 1) + 1;
    nd = 0;
    @(negedge clk);
    start = 1'b1; icode = 4'h5; ValE = 64'd9;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    start = 1'b0;
    bw = 0;
    while (busy && bw < 20) begin
      @(negedge clk);
      if (done) nd++;
      bw++;
    end
    n_cmp++;
    if (nd !== want + ((LAT > 1) ? 0 : 0)) begin
      n_bad++; $display("FAIL b2b_done_count: got %0d want %0d", nd, want);
    end
    n_cmp++;
    if (ValM !== 64'hABCD) begin
      n_bad++; $display("FAIL b2b_ValM: got %h want %h", ValM, 64'hABCD);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ic;
    logic [63:0] e, a;
    int r;
    for (int n = 0; n < 150; n++) begin
      ic = 4'($urandom);
      r  = $urandom_range(0, 9);
      e  = (r < 8) ? 64'($urandom_range(0, DEP - 1)) : (r == 8 ? 64'($urandom_range(DEP, 1000)) : rnd64());
      r  = $urandom_range(0, 9);
      a  = (r < 8) ? 64'($urandom_range(0, DEP - 1)) : rnd64();
      do_req(ic, e, a, rnd64(), n[0], "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_rw_basic();
    test_call_ret();
    test_out_of_range();
    test_no_access();
    test_reset_mid();
    test_reset_clear();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
